// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor built around a STEP-bit full-adder slice.
//   An accepted start latches the operands; the slice then walks from the LSB
//   to the MSB, STEP bits per clock, with the carry held in a register. The
//   result, carry-out and signed overflow are published together with a
//   one-cycle done pulse.
//
//   Parameters
//     WIDTH    operand/result width (>= 2)
//     STEP     bits per cycle; must divide WIDTH. N = WIDTH/STEP compute cycles.
//
//   Ports
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset (aborts any operation)
//     start    request, sampled only while busy = 0
//     a, b     operands, latched on an accepted start
//     c        carry-in for add mode (ignored when sub = 1)
//     sub      0: a + b + c, 1: a - b (computed as a + ~b + 1)
//     busy     high from the cycle after acceptance through the done cycle
//     done     one-cycle pulse; sum/carry/overflow are valid while high
//     sum      result, held until the next completion
//     carry    carry-out of the MSB (for sub, 1 = no borrow)
//     overflow signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Wide enough to address any bit of a WIDTH-bit vector.
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, res, res_nxt;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    logic [IW-1:0]    base;
    logic [STEP-1:0]  sa, sb;
    logic [STEP:0]    slice;
    logic             last;
    logic             cin_msb;

    // ------------------------------------------------------------------
    // Slice datapath: one STEP-bit add of the current operand slices plus
    // the registered carry.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in this block gets a value on every
        // path, so no latch can be inferred.
        base    = IW'(cnt) * IW'(STEP);
        sa      = opa[base +: STEP];
        sb      = opb[base +: STEP];
        slice   = {1'b0, sa} + {1'b0, sb} + {{STEP{1'b0}}, carry_reg};
        last    = (cnt == CW'(N - 1));
        // Sum bit = a ^ b ^ carry-in, so the carry into the top bit of the
        // slice is recovered from its sum bit and its two operand bits.
        cin_msb = slice[STEP-1] ^ sa[STEP-1] ^ sb[STEP-1];
        res_nxt = res;
        res_nxt[base +: STEP] = slice[STEP-1:0];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Operand, result and carry registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and result registers are cleared too, so an
            // aborted operation leaves no stale data behind.
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge.
            case (state)
                IDLE: begin
                    if (start) begin
                        opa       <= a;
                        // Subtraction is a + ~b + 1: invert b, force carry-in.
                        opb       <= sub ? ~b : b;
                        carry_reg <= sub | c;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    res       <= res_nxt;
                    carry_reg <= slice[STEP];
                    cnt       <= cnt + CW'(1);
                    if (last) begin
                        // Published on the edge that enters DONE, so the
                        // outputs are valid for the whole done cycle.
                        sum      <= res_nxt;
                        carry    <= slice[STEP];
                        overflow <= cin_msb ^ slice[STEP];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
